// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the N-host to 1-device bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [0:0] {
        ArbFixed      = 1'b0,
        ArbRoundRobin = 1'b1
    } arb_mode_e;

    // Host indices fit in three bits because at most eight hosts are supported.
    localparam int unsigned IdxWidth = 3;

    typedef struct packed {
        logic                valid;
        logic [IdxWidth-1:0] idx;
        logic                err;
    } resp_tag_t;

    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] start,
                                       input logic [63:0] size);
        return (addr & ~(size - 64'd1)) == start;
    endfunction

endpackage

// File: rtl/bus_arbiter_nhost_rr_arbiter.sv
// Same-cycle request arbiter: fixed lowest-index priority or round-robin after the last winner.
module rr_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NumHosts = 2,
    parameter arb_mode_e   Mode     = ArbRoundRobin
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumHosts-1:0] req_i,
    output logic [NumHosts-1:0] gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    logic [IdxWidth-1:0] ptr_q;
    logic [IdxWidth-1:0] ptr_d;

    // Visit hosts in priority order; the first requester reached wins.
    always_comb begin
        int   cand;
        logic hit;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        hit     = 1'b0;
        for (int k = 0; k < int'(NumHosts); k++) begin
            if (Mode == ArbFixed) begin
                cand = k;
            end else begin
                cand = (int'(ptr_q) + k + 1) % int'(NumHosts);
            end
            for (int h = 0; h < int'(NumHosts); h++) begin
                hit      = !valid_o && (h == cand) && req_i[h];
                gnt_o[h] = gnt_o[h] | hit;
                idx_o    = hit ? IdxWidth'(h) : idx_o;
                valid_o  = valid_o | hit;
            end
        end
    end

    // The pointer remembers the last winner, error grants included.
    always_comb begin
        if (valid_o) begin
            ptr_d = idx_o;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset to the last host so host 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IdxWidth'(NumHosts - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bus_arbiter_nhost.sv
// N-host to 1-device arbiter with address-window decode and a fixed-latency response tag pipeline.
module bus_arbiter_nhost
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned          NumHosts   = 2,
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter logic [AddrWidth-1:0] MemStart   = AddrWidth'(32'h0000_0000),
    parameter int unsigned          MemSize    = 65536,
    parameter int unsigned          DevLatency = 1,
    parameter int unsigned          ArbMode    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumHosts-1:0]               host_req_i,
    output logic [NumHosts-1:0]               host_gnt_o,
    input  logic [NumHosts-1:0]               host_we_i,
    input  logic [NumHosts*(DataWidth/8)-1:0] host_be_i,
    input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
    input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
    output logic [NumHosts-1:0]               host_rvalid_o,
    output logic [NumHosts*DataWidth-1:0]     host_rdata_o,
    output logic [NumHosts-1:0]               host_err_o,
    output logic                              dev_req_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [AddrWidth-1:0]              dev_addr_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    logic [IdxWidth-1:0]  win_idx_s;
    logic                 win_valid_s;
    logic                 win_we_s;
    logic [BeWidth-1:0]   win_be_s;
    logic [AddrWidth-1:0] win_addr_s;
    logic [DataWidth-1:0] win_wdata_s;
    logic                 in_range_s;
    resp_tag_t            tag_q [DevLatency];
    resp_tag_t            tag_d [DevLatency];
    resp_tag_t            fin_s;

    rr_arbiter #(
        .NumHosts (NumHosts),
        .Mode     ((ArbMode == 0) ? ArbFixed : ArbRoundRobin)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (host_req_i),
        .gnt_o   (host_gnt_o),
        .idx_o   (win_idx_s),
        .valid_o (win_valid_s)
    );

    // Select the winning host's request fields.
    always_comb begin
        logic sel;
        win_we_s    = 1'b0;
        win_be_s    = '0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        sel         = 1'b0;
        for (int h = 0; h < int'(NumHosts); h++) begin
            sel         = (win_idx_s == IdxWidth'(h));
            win_we_s    = win_we_s | (sel & host_we_i[h]);
            win_be_s    = win_be_s | ({BeWidth{sel}} & host_be_i[h*BeWidth +: BeWidth]);
            win_addr_s  = win_addr_s | ({AddrWidth{sel}} & host_addr_i[h*AddrWidth +: AddrWidth]);
            win_wdata_s = win_wdata_s | ({DataWidth{sel}} & host_wdata_i[h*DataWidth +: DataWidth]);
        end
    end

    assign in_range_s = win_valid_s && in_window(64'(win_addr_s), 64'(MemStart), 64'(MemSize));

    // Out-of-window grants never reach the device, and an idle device port is all-zero.
    always_comb begin
        if (in_range_s) begin
            dev_req_o   = 1'b1;
            dev_we_o    = win_we_s;
            dev_be_o    = win_be_s;
            dev_addr_o  = win_addr_s;
            dev_wdata_o = win_wdata_s;
        end else begin
            dev_req_o   = 1'b0;
            dev_we_o    = 1'b0;
            dev_be_o    = '0;
            dev_addr_o  = '0;
            dev_wdata_o = '0;
        end
    end

    // Next tag pipeline contents: stage 0 captures every grant, the rest shift.
    always_comb begin
        if (win_valid_s) begin
            tag_d[0] = '{valid: 1'b1, idx: win_idx_s, err: !in_range_s};
        end else begin
            tag_d[0] = '0;
        end
        for (int s = 1; s < int'(DevLatency); s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // Tag pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(DevLatency); s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(DevLatency); s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign fin_s = tag_q[DevLatency-1];

    // Steer the final-stage response to its host; error responses carry zero data.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int h = 0; h < int'(NumHosts); h++) begin
            if (fin_s.valid && (fin_s.idx == IdxWidth'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = fin_s.err;
                host_rdata_o[h*DataWidth +: DataWidth] = fin_s.err ? '0 : dev_rdata_i;
            end else begin
                host_rvalid_o[h] = 1'b0;
            end
        end
    end

    // A device answering out of step with the tags is a device fault; the tags still decide routing.
    dev_rvalid_matches_tags : assert property (
        @(posedge clk_i) disable iff (rst_i) dev_rvalid_i == (fin_s.valid && !fin_s.err)
    );

endmodule

// File: tb/tb_bus_arbiter_nhost.sv
// Bench: a round-robin/latency-1 instance and a fixed-priority/latency-3 instance share the same host stimulus.
module tb_bus_arbiter_nhost;

    localparam int NH    = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NH-1:0]    req, we;
    logic [NH*4-1:0]  be;
    logic [NH*32-1:0] addr, wdata;

    logic [NH-1:0]    gnt_a, rv_a, err_a, gnt_b, rv_b, err_b;
    logic [NH*32-1:0] rd_a, rd_b;
    logic             dreq_a, dwe_a, dreq_b, dwe_b, drv_a, drv_b;
    logic [3:0]       dbe_a, dbe_b;
    logic [31:0]      dad_a, dwd_a, dad_b, dwd_b, drd_a, drd_b;

    wire [69:0] dev_a = {dreq_a, dwe_a, dbe_a, dad_a, dwd_a};
    wire [69:0] dev_b = {dreq_b, dwe_b, dbe_b, dad_b, dwd_b};
    wire [67:0] rsp_a = {rv_a, err_a, rd_a};
    wire [67:0] rsp_b = {rv_b, err_b, rd_b};

    bus_arbiter_nhost #(.NumHosts(NH), .DevLatency(LAT_A), .ArbMode(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_gnt_o(gnt_a), .host_we_i(we),
        .host_be_i(be), .host_addr_i(addr), .host_wdata_i(wdata), .host_rvalid_o(rv_a),
        .host_rdata_o(rd_a), .host_err_o(err_a), .dev_req_o(dreq_a), .dev_we_o(dwe_a),
        .dev_be_o(dbe_a), .dev_addr_o(dad_a), .dev_wdata_o(dwd_a), .dev_rvalid_i(drv_a),
        .dev_rdata_i(drd_a)
    );

    bus_arbiter_nhost #(.NumHosts(NH), .DevLatency(LAT_B), .ArbMode(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_gnt_o(gnt_b), .host_we_i(we),
        .host_be_i(be), .host_addr_i(addr), .host_wdata_i(wdata), .host_rvalid_o(rv_b),
        .host_rdata_o(rd_b), .host_err_o(err_b), .dev_req_o(dreq_b), .dev_we_o(dwe_b),
        .dev_be_o(dbe_b), .dev_addr_o(dad_b), .dev_wdata_o(dwd_b), .dev_rvalid_i(drv_b),
        .dev_rdata_i(drd_b)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hDEAD_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = wd[k*8 +: 8];
        return r;
    endfunction

    // Behavioural SRAM devices, one per instance, answering after a fixed latency.
    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [LAT_A-1:0] pv_a;
    logic [31:0]      pd_a [LAT_A];
    logic [LAT_B-1:0] pv_b;
    logic [31:0]      pd_b [LAT_B];
    assign drv_a = pv_a[LAT_A-1];
    assign drd_a = pd_a[LAT_A-1];
    assign drv_b = pv_b[LAT_B-1];
    assign drd_b = pd_b[LAT_B-1];

    always @(posedge clk) begin
        if (rst) begin
            pv_a <= '0;
        end else begin
            pv_a[0] <= dreq_a;
            pd_a[0] <= dwe_a ? 32'h0 : mem_a[dad_a[15:2]];
            for (int i = 1; i < LAT_A; i++) begin pv_a[i] <= pv_a[i-1]; pd_a[i] <= pd_a[i-1]; end
            if (dreq_a && dwe_a) mem_a[dad_a[15:2]] <= merge(mem_a[dad_a[15:2]], dwd_a, dbe_a);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            pv_b <= '0;
        end else begin
            pv_b[0] <= dreq_b;
            pd_b[0] <= dwe_b ? 32'h0 : mem_b[dad_b[15:2]];
            for (int j = 1; j < LAT_B; j++) begin pv_b[j] <= pv_b[j-1]; pd_b[j] <= pd_b[j-1]; end
            if (dreq_b && dwe_b) mem_b[dad_b[15:2]] <= merge(mem_b[dad_b[15:2]], dwd_b, dbe_b);
        end
    end

    // Reference model: pending responses per instance, each due at a known cycle.
    typedef struct {
        int          due;
        int          host;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   last_a, last_b, cyc, win_a, win_b;
    bit   inr_a, inr_b;
    logic [NH-1:0] egnt_a, egnt_b;
    logic [69:0]   edev_a, edev_b;
    logic [67:0]   ersp_a, ersp_b;
    int   checks = 0;
    int   errors = 0;

    function automatic int pick(input logic [NH-1:0] r, input bit rr, input int last);
        int w;
        int h;
        w = -1;
        for (int k = 1; k <= NH; k++) begin
            h = rr ? (last + k) % NH : k - 1;
            if (w < 0 && r[h]) w = h;
        end
        return w;
    endfunction

    function automatic logic [31:0] haddr(input int h);
        return addr[h*32 +: 32];
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return a < 32'h0001_0000;
    endfunction

    function automatic logic [67:0] resp_of(input exp_t e);
        logic [NH-1:0]    v;
        logic [NH-1:0]    er;
        logic [NH*32-1:0] d;
        v = '0; er = '0; d = '0;
        v[e.host]  = 1'b1;
        er[e.host] = e.err;
        d[e.host*32 +: 32] = e.data;
        return {v, er, d};
    endfunction

    task automatic model_eval();
        win_a = pick(req, 1'b1, last_a);
        win_b = pick(req, 1'b0, last_b);
        egnt_a = '0; egnt_b = '0; edev_a = '0; edev_b = '0; ersp_a = '0; ersp_b = '0;
        inr_a = (win_a >= 0) && in_win(haddr(win_a));
        inr_b = (win_b >= 0) && in_win(haddr(win_b));
        if (win_a >= 0) egnt_a[win_a] = 1'b1;
        if (win_b >= 0) egnt_b[win_b] = 1'b1;
        if (inr_a) edev_a = {1'b1, we[win_a], be[win_a*4 +: 4], haddr(win_a), wdata[win_a*32 +: 32]};
        if (inr_b) edev_b = {1'b1, we[win_b], be[win_b*4 +: 4], haddr(win_b), wdata[win_b*32 +: 32]};
        if (qa.size() > 0 && qa[0].due == cyc) ersp_a = resp_of(qa[0]);
        if (qb.size() > 0 && qb[0].due == cyc) ersp_b = resp_of(qb[0]);
    endtask

    task automatic model_commit();
        exp_t        e;
        logic [31:0] a;
        if (qa.size() > 0 && qa[0].due == cyc) void'(qa.pop_front());
        if (qb.size() > 0 && qb[0].due == cyc) void'(qb.pop_front());
        if (win_a >= 0) begin
            a = haddr(win_a);
            e.due = cyc + LAT_A; e.host = win_a; e.err = !inr_a;
            e.data = (!inr_a || we[win_a]) ? 32'h0 : ref_mem[a[15:2]];
            qa.push_back(e);
            last_a = win_a;
        end
        if (win_b >= 0) begin
            a = haddr(win_b);
            e.due = cyc + LAT_B; e.host = win_b; e.err = !inr_b;
            e.data = (!inr_b || we[win_b]) ? 32'h0 : ref_mem[a[15:2]];
            qb.push_back(e);
            last_b = win_b;
        end
        // Writes are only issued by a lone requester, so both instances perform the same one.
        if (inr_a && we[win_a]) begin
            a = haddr(win_a);
            ref_mem[a[15:2]] = merge(ref_mem[a[15:2]], wdata[win_a*32 +: 32], be[win_a*4 +: 4]);
        end
        cyc++;
    endtask

    task automatic apply(input logic [1:0] r, input logic [1:0] w, input logic [7:0] b,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req = r; we = w; be = b; addr = {a1, a0}; wdata = {d1, d0};
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        rst = 1'b1;
        qa.delete(); qb.delete();
        last_a = NH - 1; last_b = NH - 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr(input bit oor);
        logic [31:0] a;
        a = {16'h0000, 14'($urandom_range(0, 16383)), 2'b00};
        if (oor) a = a | (32'($urandom_range(1, 65535)) << 16);
        return a;
    endfunction

    task automatic test_reset();
        do_reset();
        apply(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if ({gnt_a, gnt_b, rv_a, rv_b, dreq_a, dreq_b} !== 10'b0) begin
            errors++; $display("FAIL reset_idle got=%b exp=0", {gnt_a, gnt_b, rv_a, rv_b, dreq_a, dreq_b});
        end
        checks++;
        if ({dev_a, dev_b} !== 140'b0) begin
            errors++; $display("FAIL reset_dev got=%h exp=0", {dev_a, dev_b});
        end
        advance();
    endtask

    task automatic test_rr_alternate();
        for (int i = 0; i < 12; i++) begin
            if (i < 8) apply(2'b11, 2'b00, 8'($urandom), (i < 4) ? 32'h100 : rnd_addr(1'b0),
                             (i < 4) ? 32'h100 : rnd_addr(1'b0), $urandom, $urandom);
            else apply(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
            if (i < 8) begin
                checks++;
                if (gnt_a !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_alternate i=%0d got=%b exp=%b", i, gnt_a, (i % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            checks++;
            if ({gnt_a, dev_a, rsp_a} !== {egnt_a, edev_a, ersp_a}) begin
                errors++; $display("FAIL rr_model_a i=%0d got=%h exp=%h", i, {gnt_a, dev_a, rsp_a}, {egnt_a, edev_a, ersp_a});
            end
            checks++;
            if ({gnt_b, dev_b, rsp_b} !== {egnt_b, edev_b, ersp_b}) begin
                errors++; $display("FAIL rr_model_b i=%0d got=%h exp=%h", i, {gnt_b, dev_b, rsp_b}, {egnt_b, edev_b, ersp_b});
            end
            advance();
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] r;
        for (int i = 0; i < 10; i++) begin
            r = (i < 4) ? 2'b11 : ((i < 6) ? 2'b10 : 2'b00);
            apply(r, 2'b00, 8'hFF, rnd_addr(1'b0), rnd_addr(1'b0), 32'h0, 32'h0);
            if (i < 6) begin
                checks++;
                if (gnt_b !== ((i < 4) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL fixed_prio i=%0d got=%b exp=%b", i, gnt_b, (i < 4) ? 2'b01 : 2'b10);
                end
            end
            checks++;
            if ({gnt_a, dev_a, rsp_a} !== {egnt_a, edev_a, ersp_a}) begin
                errors++; $display("FAIL fixed_model_a i=%0d got=%h exp=%h", i, {gnt_a, dev_a, rsp_a}, {egnt_a, edev_a, ersp_a});
            end
            checks++;
            if ({gnt_b, dev_b, rsp_b} !== {egnt_b, edev_b, ersp_b}) begin
                errors++; $display("FAIL fixed_model_b i=%0d got=%h exp=%h", i, {gnt_b, dev_b, rsp_b}, {egnt_b, edev_b, ersp_b});
            end
            advance();
        end
    endtask

    task automatic test_write();
        logic [31:0] exp_word;
        exp_word = (init_word(8) & 32'hFFFF_00FF) | 32'h0000_CC00;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       apply(2'b10, 2'b10, 8'h20, 32'h0, 32'h20, 32'h0, 32'hAABB_CCDD);
                4:       apply(2'b10, 2'b00, 8'hF0, 32'h0, 32'h20, 32'h0, 32'h0);
                default: apply(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
            endcase
            if (i == 0) begin
                checks++;
                if ({dreq_a, dwe_a, dbe_a, dwd_a} !== {1'b1, 1'b1, 4'b0010, 32'hAABB_CCDD}) begin
                    errors++; $display("FAIL write_dev got=%h exp=%h", {dreq_a, dwe_a, dbe_a, dwd_a}, {1'b1, 1'b1, 4'b0010, 32'hAABB_CCDD});
                end
            end
            if (i == 1) begin
                checks++;
                if ({rv_a, err_a} !== 4'b1000) begin
                    errors++; $display("FAIL write_resp got=%b exp=1000", {rv_a, err_a});
                end
            end
            if (i == 5) begin
                checks++;
                if ({rv_a, rd_a[63:32]} !== {2'b10, exp_word}) begin
                    errors++; $display("FAIL write_readback got=%h exp=%h", {rv_a, rd_a[63:32]}, {2'b10, exp_word});
                end
            end
            checks++;
            if ({gnt_a, dev_a, rsp_a} !== {egnt_a, edev_a, ersp_a}) begin
                errors++; $display("FAIL write_model_a i=%0d got=%h exp=%h", i, {gnt_a, dev_a, rsp_a}, {egnt_a, edev_a, ersp_a});
            end
            checks++;
            if ({gnt_b, dev_b, rsp_b} !== {egnt_b, edev_b, ersp_b}) begin
                errors++; $display("FAIL write_model_b i=%0d got=%h exp=%h", i, {gnt_b, dev_b, rsp_b}, {egnt_b, edev_b, ersp_b});
            end
            advance();
        end
    endtask

    task automatic test_error();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       apply(2'b01, 2'b00, 8'h0F, 32'h0001_0000, 32'h0, 32'h0, 32'h0);
                4:       apply(2'b01, 2'b00, 8'h0F, 32'h0000_FFFC, 32'h0, 32'h0, 32'h0);
                default: apply(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
            endcase
            if (i == 0) begin
                checks++;
                if ({gnt_a, gnt_b, dreq_a, dreq_b} !== 6'b010100) begin
                    errors++; $display("FAIL error_grant got=%b exp=010100", {gnt_a, gnt_b, dreq_a, dreq_b});
                end
            end
            if (i == 1) begin
                checks++;
                if ({rv_a, err_a, rd_a[31:0]} !== {2'b01, 2'b01, 32'h0}) begin
                    errors++; $display("FAIL error_resp_a got=%h exp=%h", {rv_a, err_a, rd_a[31:0]}, {2'b01, 2'b01, 32'h0});
                end
            end
            if (i == 3) begin
                checks++;
                if ({rv_b, err_b} !== 4'b0101) begin
                    errors++; $display("FAIL error_resp_b got=%b exp=0101", {rv_b, err_b});
                end
            end
            if (i == 5) begin
                checks++;
                if ({rv_a, err_a, rd_a[31:0]} !== {2'b01, 2'b00, init_word(16383)}) begin
                    errors++; $display("FAIL top_of_window got=%h exp=%h", {rv_a, err_a, rd_a[31:0]}, {2'b01, 2'b00, init_word(16383)});
                end
            end
            checks++;
            if ({gnt_a, dev_a, rsp_a} !== {egnt_a, edev_a, ersp_a}) begin
                errors++; $display("FAIL error_model_a i=%0d got=%h exp=%h", i, {gnt_a, dev_a, rsp_a}, {egnt_a, edev_a, ersp_a});
            end
            checks++;
            if ({gnt_b, dev_b, rsp_b} !== {egnt_b, edev_b, ersp_b}) begin
                errors++; $display("FAIL error_model_b i=%0d got=%h exp=%h", i, {gnt_b, dev_b, rsp_b}, {egnt_b, edev_b, ersp_b});
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int grants_b;
        int resps_b;
        grants_b = 0;
        resps_b  = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) apply(2'($urandom_range(1, 3)), 2'b00, 8'($urandom),
                              rnd_addr($urandom_range(0, 3) == 0), rnd_addr($urandom_range(0, 3) == 0),
                              $urandom, $urandom);
            else apply(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
            if (egnt_b != 2'b00) grants_b++;
            if (rv_b != 2'b00) resps_b++;
            checks++;
            if ({gnt_a, dev_a, rsp_a} !== {egnt_a, edev_a, ersp_a}) begin
                errors++; $display("FAIL b2b_model_a i=%0d got=%h exp=%h", i, {gnt_a, dev_a, rsp_a}, {egnt_a, edev_a, ersp_a});
            end
            checks++;
            if ({gnt_b, dev_b, rsp_b} !== {egnt_b, edev_b, ersp_b}) begin
                errors++; $display("FAIL b2b_model_b i=%0d got=%h exp=%h", i, {gnt_b, dev_b, rsp_b}, {egnt_b, edev_b, ersp_b});
            end
            advance();
        end
        checks++;
        if (resps_b !== grants_b) begin
            errors++; $display("FAIL b2b_no_drops got=%0d exp=%0d", resps_b, grants_b);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 2; i++) begin
            apply(2'b11, 2'b00, 8'hFF, rnd_addr(1'b0), rnd_addr(1'b0), 32'h0, 32'h0);
            advance();
        end
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 5) apply(2'b11, 2'b00, 8'hFF, rnd_addr(1'b0), rnd_addr(1'b0), 32'h0, 32'h0);
            else apply(2'b00, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
            if (i < 5) begin
                checks++;
                if ({rv_a, rv_b} !== 4'b0000) begin
                    errors++; $display("FAIL flush_no_rvalid i=%0d got=%b exp=0000", i, {rv_a, rv_b});
                end
            end
            if (i == 5) begin
                checks++;
                if ({gnt_a, gnt_b} !== 4'b0101) begin
                    errors++; $display("FAIL first_after_reset got=%b exp=0101", {gnt_a, gnt_b});
                end
            end
            checks++;
            if ({gnt_a, dev_a, rsp_a} !== {egnt_a, edev_a, ersp_a}) begin
                errors++; $display("FAIL flush_model_a i=%0d got=%h exp=%h", i, {gnt_a, dev_a, rsp_a}, {egnt_a, edev_a, ersp_a});
            end
            checks++;
            if ({gnt_b, dev_b, rsp_b} !== {egnt_b, edev_b, ersp_b}) begin
                errors++; $display("FAIL flush_model_b i=%0d got=%h exp=%h", i, {gnt_b, dev_b, rsp_b}, {egnt_b, edev_b, ersp_b});
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem_a[i]   = init_word(i);
            mem_b[i]   = init_word(i);
            ref_mem[i] = init_word(i);
        end
        cyc = 0;
        test_reset();
        test_rr_alternate();
        test_fixed_priority();
        test_write();
        test_error();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_nhost.md
Name: bus_arbiter_nhost

Overview:
- Parametrised N-host to 1-device arbiter for the ECP5 Ibex SoC; replaces the hard-wired instr/data SRAM mux with a pipelined, latency-correct block.
- Grants the device in the same cycle as the request, using fixed-priority or round-robin arbitration.
- Routes fixed-latency responses back to the originating host through a tag pipeline.
- Answers accesses outside the device window with an error response instead of dropping them.

Parameters:
NumHosts, 2, number of host ports (1..8); index 0 = instr, 1 = data in the default SoC
AddrWidth, 32, address width
DataWidth, 32, data width; byte enables are DataWidth/8 wide
MemStart, 32'h0000_0000, device window base; must be aligned to MemSize
MemSize, 65536, device window size in bytes; must be a power of two
DevLatency, 1, cycles from dev_req_o to response (1..4)
ArbMode, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk_i  in  1  system clock; all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
host_req_i  in  NumHosts  per-host request
host_gnt_o  out  NumHosts  per-host grant; one-hot or zero
host_we_i  in  NumHosts  per-host write enable
host_be_i  in  NumHosts*DataWidth/8  per-host byte enables, packed by host index
host_addr_i  in  NumHosts*AddrWidth  per-host address, packed
host_wdata_i  in  NumHosts*DataWidth  per-host write data, packed
host_rvalid_o  out  NumHosts  per-host response valid
host_rdata_o  out  NumHosts*DataWidth  per-host read data
host_err_o  out  NumHosts  per-host error; qualified by host_rvalid_o
dev_req_o  out  1  device request
dev_we_o  out  1  device write enable
dev_be_o  out  DataWidth/8  device byte enables
dev_addr_o  out  AddrWidth  device address, full width passed through
dev_wdata_o  out  DataWidth  device write data
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DataWidth  device read data

Behaviour:
- Clocking/reset: one clock domain. Reset is synchronous and active-high on rst_i, sampled at the clk_i edge.
- Reset state: all response pipeline stages invalid; round-robin pointer = NumHosts-1, so host 0 wins first; every registered output 0.
- Arbitration (combinational):
  - Candidates are the hosts with host_req_i high.
  - ArbMode=0: lowest-index candidate wins.
  - ArbMode=1: first candidate searching upward from pointer+1, modulo NumHosts.
  - The winner gets host_gnt_o[w]=1 in the same cycle; the request is accepted on that edge.
- Address decode: the winner is "in range" when (addr & ~(MemSize-1)) == MemStart.
  - In range: dev_req_o=1, and dev_we/be/addr/wdata carry the winner's fields.
  - Out of range: the host is still granted, but dev_req_o=0 and the device does not see the access.
  - When dev_req_o=0, all dev_* outputs are driven to 0.
- Pointer update: on any accepted grant, including error grants, the round-robin pointer becomes w. It holds when there is no grant.
- Response tag pipeline: DevLatency stages, each holding {valid, host index, err}. Stage 0 loads on every accepted grant; stages shift every cycle.
- Response at the final stage, if valid:
  - host_rvalid_o[idx]=1.
  - err=0: host_rdata_o[idx]=dev_rdata_i, host_err_o[idx]=0.
  - err=1: host_rdata_o[idx]=0, host_err_o[idx]=1.
  - Non-addressed hosts see rvalid=0, rdata=0, err=0.
- Writes produce a response exactly like reads (Ibex requires rvalid on writes).
- Throughput: one grant per cycle, back-to-back, with no bubbles.
- Latency: request to rvalid is exactly DevLatency cycles, for both in-range and error accesses.
- Device response check:
  - dev_rvalid_i must equal (final stage valid && !err).
  - The block asserts this in simulation only; a mismatch is a device fault, and the tag pipeline stays authoritative.
- Reset mid-operation: in-flight tags are discarded and no rvalid is produced afterwards.
- Boundary cases:
  - All hosts idle: no grant, pointer unchanged.
  - NumHosts=1: arbitration degenerates to a pass-through; the pointer is unused.
  - The highest address of the window is in range; MemStart+MemSize is out of range.

Decomposition:
- Shared package bus_arbiter_pkg holds:
  - arb_mode_e {ArbFixed, ArbRoundRobin}
  - the resp_tag_t struct {valid, idx, err}
  - the function in_window(addr, start, size)
- One sub-module, rr_arbiter: NumHosts req in, one-hot gnt plus index out, with mode and pointer handling.
- The tag pipeline and decode stay in the top of the block.

Test Plan:
- Defaults, both hosts request addr 0x100 every cycle, ArbMode=1 -> grants alternate 0,1,0,1. Each rvalid arrives 1 cycle after its grant at the granted host only, with rdata matching the preloaded word.
- ArbMode=0, both hosts request continuously -> host 0 granted every cycle; host 1 starves. Drop host 0 req -> host 1 granted in that same cycle.
- Host 1 writes be=4'b0010, wdata=0xAABBCCDD to 0x20 -> dev_we_o=1 and dev_be_o=0010 in the grant cycle, rvalid the next cycle, err=0. Readback of 0x20 reflects the single-byte update.
- Host 0 reads 0x0001_0000 (MemSize=64k) -> granted, dev_req_o=0; rvalid with err=1 and rdata=0 after DevLatency. A read of 0x0000_FFFC -> err=0.
- DevLatency=3, 5 back-to-back reads mixing hosts -> each rvalid arrives exactly 3 cycles after its grant, in order, on the correct host; no drops.
- rst_i asserted for one cycle with 2 tags in flight -> no rvalid in the following cycles; first grant after release goes to host 0.
